// File: rtl/uart_rx_buffered.sv
// UART receiver (8N1, or 8E1 when UART_RX_PARITY_EN is defined)
// feeding a small FIFO with a valid/ready read port.
module uart_rx_buffered #(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       serial_in,
    output logic [7:0] data_out,
    output logic       data_out_valid,
    input  logic       data_out_ready,
    output logic       overflow,
    output logic       frame_error,
    output logic       parity_error
);

    localparam int BIT_TIME    = CLOCK_FREQ / BAUD_RATE;
    localparam int SAMPLE_TIME = BIT_TIME / 2;
    localparam int CW          = $clog2(BIT_TIME + 1);
    localparam int AW          = $clog2(FIFO_DEPTH);

    localparam logic [CW-1:0] SAMPLE_LAST = CW'(SAMPLE_TIME - 1);
    localparam logic [CW-1:0] BIT_LAST    = CW'(BIT_TIME - 1);
    localparam logic [AW:0]   FULL_COUNT  = (AW + 1)'(FIFO_DEPTH);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_START     = 3'd1;
    localparam logic [2:0] S_DATA      = 3'd2;
    localparam logic [2:0] S_PARITY    = 3'd3;
    localparam logic [2:0] S_STOP      = 3'd4;
    localparam logic [2:0] S_WAIT_IDLE = 3'd5;

`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] S_AFTER_DATA = S_PARITY;
`else
    localparam logic [2:0] S_AFTER_DATA = S_STOP;
`endif

    logic          sync1;
    logic          sync2;
    logic          rx;
    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          par_bad;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;

    logic          full;
    logic          do_pop;
    logic          stop_hit;
    logic          push_req;
    logic          wr_en;

    assign rx       = sync2;
    assign full     = (count == FULL_COUNT);
    assign do_pop   = data_out_valid && data_out_ready;
    assign stop_hit = (state == S_STOP) && (cnt == BIT_LAST);
    assign push_req = stop_hit && rx && !par_bad;
    assign wr_en    = push_req && (!full || do_pop);

    assign data_out_valid = (count != '0);
    assign data_out       = mem[rd_ptr];

    // Two-flop synchronizer; idles high so reset looks like an idle line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= serial_in;
            sync2 <= sync1;
        end
    end

    // Frame FSM: mid-bit sampling driven by a per-bit cycle counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    cnt     <= '0;
                    bit_idx <= '0;
                    if (!rx) state <= S_START;
                end
                S_START: begin
                    if (cnt == SAMPLE_LAST) begin
                        cnt   <= '0;
                        state <= rx ? S_IDLE : S_DATA;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt     <= '0;
                        shreg   <= {rx, shreg[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) state <= S_AFTER_DATA;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_PARITY, S_STOP: begin
                    if (cnt == BIT_LAST) begin
                        cnt <= '0;
                        if (state == S_PARITY) state <= S_STOP;
                        else state <= rx ? S_IDLE : S_WAIT_IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_WAIT_IDLE: begin
                    if (rx) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef UART_RX_PARITY_EN
    // Parity verdict is held until the stop bit so a frame error can win.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_bad <= 1'b0;
        end else if (state == S_IDLE) begin
            par_bad <= 1'b0;
        end else if (state == S_PARITY && cnt == BIT_LAST) begin
            par_bad <= (^shreg) ^ rx;
        end
    end

    // Parity error pulses only when the stop bit itself was good.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) parity_error <= 1'b0;
        else        parity_error <= stop_hit && rx && par_bad;
    end
`else
    assign par_bad      = 1'b0;
    assign parity_error = 1'b0;
`endif

    // Frame and overflow pulses, one cycle each, at most one per frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_error <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            frame_error <= stop_hit && !rx;
            overflow    <= push_req && full && !do_pop;
        end
    end

    // Receive FIFO; a pop on a full FIFO frees the slot for a same-cycle push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= shreg;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            unique case ({wr_en, do_pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_buffered.sv
// Randomized self-checking bench for uart_rx_buffered.
// Frames are built bit by bit; a byte queue is the expected stream.
module tb_uart_rx_buffered;

    localparam int CF    = 10_000_000;
    localparam int BR    = 115_200;
    localparam int BIT   = CF / BR;
    localparam int SMP   = BIT / 2;
    localparam int DEPTH = 4;
    // 100-cycle glitch at 434 cycles/bit, scaled to this bit time.
    localparam int GLITCH = (100 * BIT) / 434;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       serial_in = 1'b1;
    logic [7:0] data_out;
    logic       data_out_valid;
    logic       data_out_ready;
    logic       overflow;
    logic       frame_error;
    logic       parity_error;

    logic rdy_fix = 1'b0;
    logic rand_rdy = 1'b0;
    logic rnd_bit = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [7:0] got[$];
    int         got_base = 0;
    logic [7:0] exp_q[$];
    int         rise_q[$];
    int         stop_q[$];
    int         ovf_n = 0;
    int         fe_n = 0;
    int         pe_n = 0;
    int         multi_n = 0;
    int         vcyc_n = 0;
    logic       prev_v = 1'b0;

    assign data_out_ready = rand_rdy ? rnd_bit : rdy_fix;

    uart_rx_buffered #(
        .CLOCK_FREQ(CF),
        .BAUD_RATE (BR),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .serial_in     (serial_in),
        .data_out      (data_out),
        .data_out_valid(data_out_valid),
        .data_out_ready(data_out_ready),
        .overflow      (overflow),
        .frame_error   (frame_error),
        .parity_error  (parity_error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1 rnd_bit = 1'($urandom % 2);
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (data_out_valid && data_out_ready) got.push_back(data_out);
            ovf_n += int'(overflow);
            fe_n  += int'(frame_error);
            pe_n  += int'(parity_error);
            if (int'(overflow) + int'(frame_error) + int'(parity_error) > 1)
                multi_n++;
            if (data_out_valid) vcyc_n++;
            if (data_out_valid && !prev_v) rise_q.push_back(cyc);
            prev_v = data_out_valid;
        end else begin
            prev_v = 1'b0;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
                     tag, obs, obs, exp, exp);
        end
    endtask

    // Hold the line at v for n clocks; called and returns at posedge+1.
    task automatic drive(input logic v, input int n);
        serial_in = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop,
                              input logic par_ok);
        drive(1'b0, BIT);
        for (int i = 0; i < 8; i++) drive(b[i], BIT);
`ifdef UART_RX_PARITY_EN
        drive(par_ok ? ^b : ~^b, BIT);
`else
        if (!par_ok) $display("note: parity not compiled in");
`endif
        stop_q.push_back(cyc);
        drive(stop, BIT);
        drive(1'b1, BIT);
    endtask

    task automatic check_stream(input string tag);
        int n;
        n = got.size() - got_base;
        check({tag, "_count"}, n, exp_q.size());
        for (int i = 0; i < exp_q.size() && i < n; i++)
            check({tag, "_byte"}, int'(got[got_base + i]), int'(exp_q[i]));
        got_base = got.size();
        exp_q.delete();
    endtask

    initial begin
        int fe0, pe0, ov0, v0;
        logic [7:0] b;
        logic bad_stop, bad_par;

        // Reset state, line idle.
        repeat (3) @(posedge clk);
        #1;
        check("rst_data", int'(data_out), 0);
        check("rst_valid", int'(data_out_valid), 0);
        check("rst_ovf", int'(overflow), 0);
        check("rst_fe", int'(frame_error), 0);
        check("rst_pe", int'(parity_error), 0);
        rst_n = 1'b1;

        // Idle line: nothing for 10000 cycles.
        rdy_fix = 1'b1;
        repeat (10000) @(posedge clk);
        #1;
        check("idle_valid_cycles", vcyc_n, 0);
        check("idle_pulses", ovf_n + fe_n + pe_n, 0);

        // Four bytes with ready high; valid one cycle after stop sample.
        rise_q.delete();
        stop_q.delete();
        fe0 = fe_n; pe0 = pe_n; ov0 = ovf_n;
        foreach (exp_q[i]) exp_q.delete();
        exp_q = '{8'h78, 8'h79, 8'h7a, 8'h0d};
        send_frame(8'h78, 1'b1, 1'b1);
        send_frame(8'h79, 1'b1, 1'b1);
        send_frame(8'h7a, 1'b1, 1'b1);
        send_frame(8'h0d, 1'b1, 1'b1);
        check("basic_rises", rise_q.size(), 4);
        for (int i = 0; i < 4 && i < rise_q.size(); i++)
            check("basic_latency", rise_q[i] - stop_q[i], SMP + 3);
        check_stream("basic");
        check("basic_pulses", (ovf_n - ov0) + (fe_n - fe0) + (pe_n - pe0), 0);

        // Overflow: ready low, five bytes into a four-entry FIFO.
        rdy_fix = 1'b0;
        ov0 = ovf_n; fe0 = fe_n;
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 1'b1);
        check("ovf_pulses", ovf_n - ov0, 1);
        check("ovf_no_fe", fe_n - fe0, 0);
        check("ovf_held", got.size() - got_base, 0);
        rdy_fix = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        exp_q = '{8'h01, 8'h02, 8'h03, 8'h04};
        check_stream("ovf_drain");

        // Short low glitch on idle line, then a real byte.
        fe0 = fe_n; pe0 = pe_n; ov0 = ovf_n;
        drive(1'b0, GLITCH);
        drive(1'b1, 2 * BIT);
        check("glitch_no_byte", got.size() - got_base, 0);
        check("glitch_no_pulse", (ovf_n - ov0) + (fe_n - fe0) + (pe_n - pe0), 0);
        exp_q.push_back(8'h55);
        send_frame(8'h55, 1'b1, 1'b1);
        check_stream("glitch_next");

        // Bad stop bit.
        fe0 = fe_n;
        send_frame(8'ha5, 1'b0, 1'b1);
        check("fe_pulse", fe_n - fe0, 1);
        check("fe_no_byte", got.size() - got_base, 0);
        exp_q.push_back(8'h3e);
        send_frame(8'h3e, 1'b1, 1'b1);
        check_stream("fe_next");

        // Reset in the middle of data bit 4 of 8'hff.
        fe0 = fe_n; pe0 = pe_n; ov0 = ovf_n;
        drive(1'b0, BIT);
        for (int i = 0; i < 4; i++) drive(1'b1, BIT);
        drive(1'b1, BIT / 2);
        rst_n = 1'b0;
        #2;
        check("midrst_valid", int'(data_out_valid), 0);
        check("midrst_data", int'(data_out), 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(1'b1, 6 * BIT);
        check("midrst_no_byte", got.size() - got_base, 0);
        check("midrst_no_pulse", (ovf_n - ov0) + (fe_n - fe0) + (pe_n - pe0), 0);
        exp_q.push_back(8'h31);
        send_frame(8'h31, 1'b1, 1'b1);
        check_stream("midrst_next");
`ifdef UART_RX_PARITY_EN
        pe0 = pe_n;
        send_frame(8'h31, 1'b1, 1'b0);
        check("par_pulse", pe_n - pe0, 1);
        check("par_no_byte", got.size() - got_base, 0);
`endif

        // Random frames, random consumer back-pressure.
        fe0 = fe_n; pe0 = pe_n; ov0 = ovf_n;
        rand_rdy = 1'b1;
        begin
            int efe, epe;
            efe = 0; epe = 0;
            for (int k = 0; k < 12; k++) begin
                b = 8'($urandom);
                bad_stop = ($urandom % 5) == 0;
`ifdef UART_RX_PARITY_EN
                bad_par = ($urandom % 4) == 0;
`else
                bad_par = 1'b0;
`endif
                if (bad_stop) efe++;
                else if (bad_par) epe++;
                else exp_q.push_back(b);
                send_frame(b, !bad_stop, !bad_par);
                drive(1'b1, $urandom_range(0, BIT));
            end
            rand_rdy = 1'b0;
            @(posedge clk);
            #1;
            rdy_fix = 1'b1;
            repeat (10) @(posedge clk);
            #1;
            check_stream("rand");
            check("rand_fe", fe_n - fe0, efe);
            check("rand_pe", pe_n - pe0, epe);
            check("rand_ovf", ovf_n - ov0, 0);
        end
        v0 = int'(data_out_valid);
        check("end_empty", v0, 0);
        check("one_pulse_per_frame", multi_n, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
